// File: rtl/ibex_mem_arbiter.sv
// Two-requester (instruction/data) arbiter onto a single-ported memory with a fixed
// one-cycle read latency. Round-robin on contention; one response per grant.
module ibex_mem_arbiter #(
    parameter int AddrWidth = 15,
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 instr_req_i,
    output logic                 instr_gnt_o,
    input  logic [AddrWidth-1:0] instr_addr_i,
    input  logic                 instr_we_i,
    input  logic [DataWidth-1:0] instr_wdata_i,
    input  logic [DataWidth-1:0] instr_strb_i,
    output logic                 instr_rvalid_o,
    output logic [DataWidth-1:0] instr_rdata_o,

    input  logic                 data_req_i,
    output logic                 data_gnt_o,
    input  logic [AddrWidth-1:0] data_addr_i,
    input  logic                 data_we_i,
    input  logic [DataWidth-1:0] data_wdata_i,
    input  logic [DataWidth-1:0] data_strb_i,
    output logic                 data_rvalid_o,
    output logic [DataWidth-1:0] data_rdata_o,

    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [DataWidth-1:0] mem_strb_o,
    input  logic [DataWidth-1:0] mem_rdata_i,

    output logic [15:0]          conflict_cnt_o
);

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    port_e       last_grant_reg;
    port_e       resp_owner_reg;
    logic        resp_valid_reg;
    logic [15:0] conflict_cnt_reg;

    logic        grant_instr;
    logic        grant_data;
    logic        both_req;

    assign both_req = instr_req_i && data_req_i;

    // On contention the port that did not win last time gets the slot.
    always_comb begin
        grant_instr = 1'b0;
        grant_data  = 1'b0;
        if (!rst_i) begin
            if (both_req) begin
                grant_data  = (last_grant_reg == PORT_INSTR);
                grant_instr = (last_grant_reg == PORT_DATA);
            end else begin
                grant_instr = instr_req_i;
                grant_data  = data_req_i;
            end
        end
    end

    assign instr_gnt_o = grant_instr;
    assign data_gnt_o  = grant_data;
    assign mem_req_o   = grant_instr || grant_data;

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_strb_o  = '0;
        if (grant_data) begin
            mem_we_o    = data_we_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
            mem_strb_o  = data_strb_i;
        end else if (grant_instr) begin
            mem_we_o    = instr_we_i;
            mem_addr_o  = instr_addr_i;
            mem_wdata_o = instr_wdata_i;
            mem_strb_o  = instr_strb_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_reg   <= PORT_INSTR;
            resp_owner_reg   <= PORT_INSTR;
            resp_valid_reg   <= 1'b0;
            conflict_cnt_reg <= 16'h0000;
        end else begin
            if (grant_instr || grant_data) begin
                last_grant_reg <= grant_data ? PORT_DATA : PORT_INSTR;
                resp_owner_reg <= grant_data ? PORT_DATA : PORT_INSTR;
            end
            resp_valid_reg <= grant_instr || grant_data;
            if (both_req && (conflict_cnt_reg != 16'hFFFF)) begin
                conflict_cnt_reg <= conflict_cnt_reg + 16'h0001;
            end
        end
    end

    assign conflict_cnt_o = conflict_cnt_reg;

    // Gating with rst_i drops a response whose grant preceded a reset.
    assign instr_rvalid_o = !rst_i && resp_valid_reg && (resp_owner_reg == PORT_INSTR);
    assign data_rvalid_o  = !rst_i && resp_valid_reg && (resp_owner_reg == PORT_DATA);
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : '0;

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Directed bench for ibex_mem_arbiter: each task drives one scenario and checks
// grants, memory-side muxing, responses and the conflict counter inline.
module tb_ibex_mem_arbiter;

    localparam int AW = 15;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          instr_req, instr_gnt, instr_we, instr_rvalid;
    logic [AW-1:0] instr_addr;
    logic [DW-1:0] instr_wdata, instr_strb, instr_rdata;
    logic          data_req, data_gnt, data_we, data_rvalid;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata, data_strb, data_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_strb, mem_rdata;
    logic [15:0]   conflict_cnt;

    int total;
    int bad;

    ibex_mem_arbiter #(.AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_req_i    (instr_req),
        .instr_gnt_o    (instr_gnt),
        .instr_addr_i   (instr_addr),
        .instr_we_i     (instr_we),
        .instr_wdata_i  (instr_wdata),
        .instr_strb_i   (instr_strb),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .data_req_i     (data_req),
        .data_gnt_o     (data_gnt),
        .data_addr_i    (data_addr),
        .data_we_i      (data_we),
        .data_wdata_i   (data_wdata),
        .data_strb_i    (data_strb),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_strb_o     (mem_strb),
        .mem_rdata_i    (mem_rdata),
        .conflict_cnt_o (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_req = 0; instr_we = 0; instr_addr = '0; instr_wdata = '0; instr_strb = '0;
        data_req  = 0; data_we  = 0; data_addr  = '0; data_wdata  = '0; data_strb  = '0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        instr_req = 1; data_req = 1; instr_addr = 15'h0123; data_addr = 15'h0456;
        data_we = 1; data_strb = 32'hFFFFFFFF; data_wdata = 32'h12345678;
        tick();
        total++;
        if (instr_gnt !== 1'b0 || data_gnt !== 1'b0) begin
            bad++; $display("FAIL reset_gnt: got instr=%b data=%b, want 0 0", instr_gnt, data_gnt);
        end
        total++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || mem_strb !== '0) begin
            bad++; $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h strb=%h, want all 0",
                            mem_req, mem_we, mem_addr, mem_wdata, mem_strb);
        end
        total++;
        if (instr_rvalid !== 1'b0 || data_rvalid !== 1'b0 || instr_rdata !== '0 || data_rdata !== '0) begin
            bad++; $display("FAIL reset_resp: got rvalid %b/%b rdata %h/%h, want 0", instr_rvalid, data_rvalid,
                            instr_rdata, data_rdata);
        end
        total++;
        if (conflict_cnt !== 16'h0000) begin
            bad++; $display("FAIL reset_cnt: got %h want 0000", conflict_cnt);
        end
        rst = 0;
        idle_inputs();
        #1;
        $display("reset: cnt=%h gnt=%b%b", conflict_cnt, instr_gnt, data_gnt);
    endtask

    task automatic test_single_read();
        instr_req = 1; instr_addr = 15'h0010;
        #1;
        total++;
        if (instr_gnt !== 1'b1 || data_gnt !== 1'b0) begin
            bad++; $display("FAIL single_gnt: got instr=%b data=%b, want 1 0", instr_gnt, data_gnt);
        end
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 15'h0010 || mem_we !== 1'b0) begin
            bad++; $display("FAIL single_mem: got req=%b addr=%h we=%b, want 1 0010 0", mem_req, mem_addr, mem_we);
        end
        tick();
        idle_inputs();
        mem_rdata = 32'hA5A51234;
        #1;
        total++;
        if (instr_rvalid !== 1'b1 || instr_rdata !== 32'hA5A51234) begin
            bad++; $display("FAIL single_resp: got rvalid=%b rdata=%h, want 1 a5a51234", instr_rvalid, instr_rdata);
        end
        total++;
        if (data_rvalid !== 1'b0 || data_rdata !== '0 || mem_req !== 1'b0 || mem_addr !== '0) begin
            bad++; $display("FAIL single_other: got drvalid=%b drdata=%h mreq=%b maddr=%h, want 0 0 0 0",
                            data_rvalid, data_rdata, mem_req, mem_addr);
        end
        $display("single_read: addr=0010 rdata=%h", instr_rdata);
        tick();
        total++;
        if (instr_rvalid !== 1'b0) begin
            bad++; $display("FAIL single_one_pulse: got rvalid=%b want 0", instr_rvalid);
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp_data;
        logic       prev_data;
        do_reset();
        exp_data = 4'b0101;  // bit k: cycle k grant goes to data
        prev_data = 1'b0;
        instr_req = 1; data_req = 1; instr_addr = 15'h0AAA; data_addr = 15'h0555;
        for (int k = 0; k < 4; k++) begin
            mem_rdata = 32'h1000 + k;
            #1;
            total++;
            if (data_gnt !== exp_data[k] || instr_gnt !== ~exp_data[k]) begin
                bad++; $display("FAIL contend_gnt%0d: got instr=%b data=%b, want data=%b", k, instr_gnt, data_gnt, exp_data[k]);
            end
            total++;
            if (mem_addr !== (exp_data[k] ? 15'h0555 : 15'h0AAA)) begin
                bad++; $display("FAIL contend_addr%0d: got %h", k, mem_addr);
            end
            if (k > 0) begin
                total++;
                if (data_rvalid !== prev_data || instr_rvalid !== ~prev_data ||
                    (prev_data ? data_rdata : instr_rdata) !== 32'h1000 + k) begin
                    bad++; $display("FAIL contend_resp%0d: got rvalid i=%b d=%b, want d=%b", k, instr_rvalid, data_rvalid, prev_data);
                end
            end
            $display("contend cycle %0d: gnt i=%b d=%b", k, instr_gnt, data_gnt);
            prev_data = exp_data[k];
            tick();
        end
        idle_inputs();
        mem_rdata = 32'h2222;
        #1;
        total++;
        if (instr_rvalid !== 1'b1 || data_rvalid !== 1'b0 || instr_rdata !== 32'h2222) begin
            bad++; $display("FAIL contend_last_resp: got i=%b d=%b rdata=%h, want 1 0 2222", instr_rvalid, data_rvalid, instr_rdata);
        end
        total++;
        if (conflict_cnt !== 16'd4) begin
            bad++; $display("FAIL contend_cnt: got %0d want 4", conflict_cnt);
        end
        tick();
    endtask

    task automatic test_data_write();
        data_req = 1; data_we = 1; data_strb = 32'h0000FFFF; data_wdata = 32'hDEADBEEF; data_addr = 15'h7FFF;
        #1;
        total++;
        if (data_gnt !== 1'b1 || mem_we !== 1'b1 || mem_strb !== 32'h0000FFFF ||
            mem_addr !== 15'h7FFF || mem_wdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL write_mem: got gnt=%b we=%b strb=%h addr=%h wdata=%h", data_gnt, mem_we, mem_strb, mem_addr, mem_wdata);
        end
        tick();
        idle_inputs();
        #1;
        total++;
        if (data_rvalid !== 1'b1 || instr_rvalid !== 1'b0) begin
            bad++; $display("FAIL write_resp: got d=%b i=%b want 1 0", data_rvalid, instr_rvalid);
        end
        $display("data_write: addr=7fff wdata=deadbeef rvalid=%b", data_rvalid);
        tick();
    endtask

    task automatic test_reset_mid();
        data_req = 1; data_addr = 15'h0042;
        #1;
        total++;
        if (data_gnt !== 1'b1) begin
            bad++; $display("FAIL midrst_gnt: got %b want 1", data_gnt);
        end
        tick();
        idle_inputs();
        rst = 1;
        mem_rdata = 32'hCAFEF00D;
        #1;
        total++;
        if (data_rvalid !== 1'b0 || data_rdata !== '0) begin
            bad++; $display("FAIL midrst_drop: got rvalid=%b rdata=%h want 0 0", data_rvalid, data_rdata);
        end
        tick();
        rst = 0;
        #1;
        total++;
        if (data_rvalid !== 1'b0 || instr_rvalid !== 1'b0 || conflict_cnt !== 16'h0000) begin
            bad++; $display("FAIL midrst_after: got d=%b i=%b cnt=%h want 0 0 0000", data_rvalid, instr_rvalid, conflict_cnt);
        end
        instr_req = 1; data_req = 1;
        #1;
        total++;
        if (data_gnt !== 1'b1 || instr_gnt !== 1'b0) begin
            bad++; $display("FAIL midrst_contend: got i=%b d=%b want 0 1", instr_gnt, data_gnt);
        end
        $display("reset_mid: next contention gnt i=%b d=%b", instr_gnt, data_gnt);
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_alternating();
        instr_req = 1; instr_addr = 15'h0100;
        #1;
        total++;
        if (instr_gnt !== 1'b1 || data_gnt !== 1'b0) begin
            bad++; $display("FAIL alt_gnt_i: got i=%b d=%b", instr_gnt, data_gnt);
        end
        tick();
        idle_inputs();
        data_req = 1; data_addr = 15'h0200;
        mem_rdata = 32'h11111111;
        #1;
        total++;
        if (data_gnt !== 1'b1 || instr_gnt !== 1'b0 || instr_rvalid !== 1'b1 ||
            instr_rdata !== 32'h11111111 || data_rvalid !== 1'b0) begin
            bad++; $display("FAIL alt_cycle2: got gnt d=%b irv=%b irdata=%h drv=%b", data_gnt, instr_rvalid, instr_rdata, data_rvalid);
        end
        tick();
        idle_inputs();
        mem_rdata = 32'h22222222;
        #1;
        total++;
        if (data_rvalid !== 1'b1 || data_rdata !== 32'h22222222 || instr_rvalid !== 1'b0 || instr_rdata !== '0) begin
            bad++; $display("FAIL alt_cycle3: got drv=%b drdata=%h irv=%b irdata=%h", data_rvalid, data_rdata, instr_rvalid, instr_rdata);
        end
        $display("alternating: data rdata=%h", data_rdata);
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        instr_req = 1; data_req = 1;
        for (int k = 0; k < 65540; k++) begin
            @(posedge clk);
        end
        #1;
        total++;
        if (conflict_cnt !== 16'hFFFF) begin
            bad++; $display("FAIL sat_reach: got %h want ffff", conflict_cnt);
        end
        tick();
        tick();
        total++;
        if (conflict_cnt !== 16'hFFFF) begin
            bad++; $display("FAIL sat_hold: got %h want ffff", conflict_cnt);
        end
        $display("saturation: cnt=%h", conflict_cnt);
        idle_inputs();
        tick();
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_data_write();
        test_reset_mid();
        test_alternating();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ibex_mem_arbiter.md
IBEX_MEM_ARBITER -- requirements
Module: ibex_mem_arbiter

Interface
REQ-001 The block SHALL have parameter AddrWidth, default 15, meaning the word-address width of all address ports.
REQ-002 The block SHALL have parameter DataWidth, default 32, meaning the data and bitwise-strobe width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high, with ports:
- clk_i  input  1  the single clock; all state updates on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have the port instr_req_i  input  1  instruction requester request.
REQ-005 The block SHALL have these instruction-requester ports:
- instr_gnt_o  output  1  request accepted this cycle.
- instr_addr_i  input  AddrWidth  word address.
- instr_we_i  input  1  write enable.
- instr_wdata_i  input  DataWidth  write data.
- instr_strb_i  input  DataWidth  bitwise write strobe.
- instr_rvalid_o  output  1  response valid.
- instr_rdata_o  output  DataWidth  read data.
REQ-006 The block SHALL have the data-requester ports data_req_i, data_gnt_o, data_addr_i, data_we_i, data_wdata_i, data_strb_i, data_rvalid_o and data_rdata_o, with the same directions, widths and meanings as REQ-004/REQ-005.
REQ-007 The block SHALL have these memory-side ports:
- mem_req_o  output  1  memory access strobe.
- mem_we_o  output  1  memory write enable.
- mem_addr_o  output  AddrWidth  memory word address.
- mem_wdata_o  output  DataWidth  memory write data.
- mem_strb_o  output  DataWidth  memory bitwise strobe.
- mem_rdata_i  input  DataWidth  memory read data, valid one cycle after mem_req_o.
REQ-008 The block SHALL have the port conflict_cnt_o  output  16  count of cycles in which both requesters asserted req.

Function
REQ-009 Grants SHALL be combinational, same cycle as the request; at most one of instr_gnt_o, data_gnt_o is high per cycle.
REQ-010 A lone requester SHALL be granted in the cycle it asserts req.
REQ-011 When both requesters assert req, the grant SHALL go to the port not recorded in register last_grant (round-robin).
REQ-012 last_grant SHALL update to the granted port on every granted cycle and hold otherwise; its reset value is INSTR, so the first contention goes to data.
REQ-013 mem_req_o SHALL equal instr_req_i OR data_req_i, with rst_i low.
REQ-014 mem_we_o, mem_addr_o, mem_wdata_o and mem_strb_o SHALL be driven from the granted port.
- When mem_req_o is low, these outputs SHALL be 0.
REQ-015 Register resp_valid SHALL be set in the cycle after any grant, with register resp_owner recording the granted port; otherwise resp_valid is cleared.
REQ-016 The granted port's rvalid_o SHALL be high exactly one cycle after its grant, for both reads and writes.
- Back-to-back grants SHALL yield back-to-back rvalid pulses.
REQ-017 The owning port's rdata_o SHALL equal mem_rdata_i while its rvalid_o is high, and SHALL be 0 otherwise.
- Non-owning rdata_o SHALL be 0.
REQ-018 Simultaneous response delivery and new grant SHALL be supported: response for grant N and grant N+1 are in the same cycle, and throughput is 1 access per cycle.
REQ-019 conflict_cnt_o SHALL increment by 1 each cycle both req inputs are high, and SHALL saturate at 16'hFFFF (no wrap).
REQ-020 A requester SHALL hold its req and payload stable until granted; the block SHALL NOT buffer ungranted requests.

Reset
REQ-021 While rst_i is high, the block SHALL force:
- instr_gnt_o = 0, data_gnt_o = 0.
- mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, mem_strb_o = 0.
- instr_rvalid_o = 0, data_rvalid_o = 0, instr_rdata_o = 0, data_rdata_o = 0.
REQ-022 Reset SHALL clear resp_valid, resp_owner and conflict_cnt_o, and set last_grant = INSTR, on the first clock edge with rst_i high.
REQ-023 If rst_i is asserted in the cycle after a grant, the pending response SHALL be dropped.
- No rvalid SHALL appear in the first cycle after rst_i deasserts.

Verification
REQ-024 Single read: instr_req_i=1, addr=0x10, data_req_i=0 -> instr_gnt_o=1 same cycle; next cycle instr_rvalid_o=1 and instr_rdata_o=mem_rdata_i; data_rvalid_o=0.
REQ-025 Contention after reset: both req held for 4 cycles -> grants D,I,D,I; rvalid pulses follow one cycle later on the matching port; conflict_cnt_o=4.
REQ-026 Data write: data_we_i=1, strb=0x0000FFFF, wdata=0xDEADBEEF, addr=0x7FFF -> mem_we_o=1, mem_strb_o=0x0000FFFF, mem_addr_o=0x7FFF; data_rvalid_o=1 next cycle.
REQ-027 Reset mid-operation: grant to data, then rst_i=1 for 1 cycle, then 0 -> data_rvalid_o stays 0, conflict_cnt_o=0, and the next contention is granted to data.
REQ-028 Saturation: preload by holding both req for 65540 cycles -> conflict_cnt_o=0xFFFF and remains there.
REQ-029 Alternating singles: instr only, then data only, on consecutive cycles -> each is granted immediately; rvalid pulses occur on consecutive cycles with correct owner and rdata.
